// File: rtl/seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// seq_pattern_detector
//
// Serial pattern detector. Compares a single-bit serial stream against a
// runtime-programmable pattern of 1..MAX_LEN bits, with a per-bit don't-care
// mask and selectable overlapping / non-overlapping matching.
//
// Ports:
//   clk        rising-edge clock
//   rst_an     asynchronous active-low reset
//   en         sample strobe; d is consumed only on edges where en=1
//   d          serial data bit
//   pat        pattern; pat[len-1] = oldest bit, pat[0] = newest bit
//   care       per-bit compare mask (1 = compare), same ordering as pat
//   len        active pattern length (valid range 1..MAX_LEN)
//   ovl        1 = overlapping detection, 0 = non-overlapping
//   clr        synchronous clear of history, fill and counter (beats en)
//   match      one-cycle registered match pulse
//   match_cnt  saturating match counter
//   cnt_sat    high while match_cnt is all-ones
//   armed      high when the next accepted bit can complete a match
//   cfg_err    combinational; high while len==0 or len>MAX_LEN
// -----------------------------------------------------------------------------
module seq_pattern_detector #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_an,
  input  logic               en,
  input  logic               d,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [MAX_LEN-1:0] care,
  input  logic [LEN_W-1:0]   len,
  input  logic               ovl,
  input  logic               clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat,
  output logic               armed,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CFG_ERR = 2'd2
  } state_t;

  // The oldest history bit is never part of the window (the window is the
  // previous MAX_LEN-1 bits plus the current d), so it is not stored.
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W:0]     fill;
  state_t             state;

  logic [MAX_LEN-1:0] win;
  logic               cmp_ok;
  logic               reach;
  logic               hit;
  logic [LEN_W+1:0]   fill_p1;
  logic [LEN_W:0]     fill_acc;
  logic [LEN_W:0]     fill_next;
  logic [LEN_W+1:0]   fill_next_p1;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt_inc;

  assign cfg_err = (len == '0) || ({1'b0, len} > (LEN_W+1)'(MAX_LEN));

  always_comb begin
    win    = {hist, d};
    cmp_ok = 1'b1;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (((LEN_W+1)'(i) < {1'b0, len}) && care[i] && (win[i] != pat[i])) begin
        cmp_ok = 1'b0;
      end
    end
  end

  // fill+1 >= len: the bit being sampled now would be the len-th bit.
  assign fill_p1 = {1'b0, fill} + (LEN_W+2)'(1);
  assign reach   = fill_p1 >= {2'b00, len};
  assign hit     = en && !clr && !cfg_err && reach && cmp_ok;

  always_comb begin
    if (hit && !ovl) begin
      fill_acc = '0;
    end else if (fill == (LEN_W+1)'(MAX_LEN)) begin
      fill_acc = fill;
    end else begin
      fill_acc = fill + (LEN_W+1)'(1);
    end
  end

  // State view follows the fill value that will hold after this edge, so
  // armed lines up with the registered fill it describes.
  always_comb begin
    if (clr) begin
      fill_next = '0;
    end else if (en) begin
      fill_next = fill_acc;
    end else begin
      fill_next = fill;
    end
    fill_next_p1 = {1'b0, fill_next} + (LEN_W+2)'(1);
    if (cfg_err) begin
      state_next = ST_CFG_ERR;
    end else if (fill_next_p1 >= {2'b00, len}) begin
      state_next = ST_ARMED;
    end else begin
      state_next = ST_FILL;
    end
  end

  assign cnt_inc = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      hist      <= '0;
      fill      <= '0;
      state     <= ST_FILL;
      match     <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      state <= state_next;
      fill  <= fill_next;
      if (clr) begin
        hist      <= '0;
        match     <= 1'b0;
        match_cnt <= '0;
        cnt_sat   <= 1'b0;
      end else begin
        match <= hit;
        if (en) begin
          hist <= win[MAX_LEN-2:0];
        end
        if (hit) begin
          match_cnt <= cnt_inc;
          cnt_sat   <= (cnt_inc == '1);
        end
      end
    end
  end

  assign armed = (state == ST_ARMED);

endmodule

// File: tb/tb_seq_pattern_detector.sv
module tb_seq_pattern_detector;

  localparam int MAX_LEN = 8;
  localparam int CNT_MAX = 15;

  logic         clk = 1'b0;
  logic         rst_an = 1'b0;
  logic         en = 1'b0;
  logic         d = 1'b0;
  logic [7:0]   pat = '0;
  logic [7:0]   care = '1;
  logic [3:0]   len = 4'd2;
  logic         ovl = 1'b0;
  logic         clr = 1'b0;
  logic         match;
  logic [3:0]   match_cnt;
  logic         cnt_sat;
  logic         armed;
  logic         cfg_err;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic sq[$];          // accepted bits, sq[0] = newest
  int   m_fill  = 0;
  int   m_cnt   = 0;
  logic m_match = 1'b0;

  seq_pattern_detector #(.MAX_LEN(8), .LEN_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_an(rst_an), .en(en), .d(d), .pat(pat), .care(care),
    .len(len), .ovl(ovl), .clr(clr), .match(match), .match_cnt(match_cnt),
    .cnt_sat(cnt_sat), .armed(armed), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic len_valid();
    return (len >= 1) && (len <= MAX_LEN);
  endfunction

  // Rules applied to one clock edge, given the inputs presented before it.
  task automatic model_edge();
    logic hit;
    logic b;
    if (clr) begin
      sq.delete();
      m_fill  = 0;
      m_cnt   = 0;
      m_match = 1'b0;
    end else if (en) begin
      hit = len_valid() && (m_fill + 1 >= int'(len));
      for (int j = 0; j < int'(len) && j < MAX_LEN; j++) begin
        if (j == 0) b = d;
        else if (j - 1 < sq.size()) b = sq[j-1];
        else b = 1'b0;
        if (care[j] && (b !== pat[j])) hit = 1'b0;
      end
      sq.push_front(d);
      if (sq.size() > MAX_LEN) void'(sq.pop_back());
      m_match = hit;
      if (hit && m_cnt < CNT_MAX) m_cnt++;
      if (hit && !ovl) m_fill = 0;
      else if (m_fill < MAX_LEN) m_fill++;
    end else begin
      m_match = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".match"},   32'(match),     32'(m_match));
    check({tag, ".cnt"},     32'(match_cnt), 32'(m_cnt));
    check({tag, ".sat"},     32'(cnt_sat),   32'(m_cnt == CNT_MAX));
    check({tag, ".armed"},   32'(armed),     32'(len_valid() && (m_fill + 1 >= int'(len))));
    check({tag, ".cfg_err"}, 32'(cfg_err),   32'(!len_valid()));
  endtask

  // Present inputs away from the edge, advance one edge, then compare.
  task automatic tick(input logic e, input logic b, input logic c, input string tag);
    en  = e;
    d   = b;
    clr = c;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic bits(input logic [31:0] v, input int n, input logic o, input string tag);
    for (int k = n - 1; k >= 0; k--) tick(1'b1, v[k], 1'b0, tag);
    en = 1'b0;
  endtask

  task automatic do_clear();
    tick(1'b0, 1'b0, 1'b1, "clr");
    clr = 1'b0;
  endtask

  task automatic mid_reset();
    #2 rst_an = 1'b0;
    #1;
    sq.delete();
    m_fill  = 0;
    m_cnt   = 0;
    m_match = 1'b0;
    check("rst.match", 32'(match), 0);
    check("rst.cnt",   32'(match_cnt), 0);
    check("rst.sat",   32'(cnt_sat), 0);
    check("rst.armed", 32'(armed), 0);
    check("rst.cfg_err", 32'(cfg_err), 32'(!len_valid()));
    @(negedge clk);
    rst_an = 1'b1;
  endtask

  initial begin
    // reset state
    #3;
    check("reset.match", 32'(match), 0);
    check("reset.cnt",   32'(match_cnt), 0);
    check("reset.armed", 32'(armed), 0);
    check("reset.cfg_err", 32'(cfg_err), 0);
    @(negedge clk);
    rst_an = 1'b1;

    // 1: "00", non-overlapping, six zeros
    len = 4'd2; pat = 8'h00; care = 8'hFF; ovl = 1'b0;
    bits(32'h0, 6, 1'b0, "t1");
    check("t1.total", 32'(match_cnt), 3);
    do_clear();

    // 2: same, overlapping
    ovl = 1'b1;
    bits(32'h0, 6, 1'b1, "t2");
    check("t2.total", 32'(match_cnt), 5);
    do_clear();

    // 3: 1011 over 1,0,1,1,0,1,1
    len = 4'd4; pat = 8'b1011; ovl = 1'b1;
    bits(32'b1011011, 7, 1'b1, "t3o");
    check("t3o.total", 32'(match_cnt), 2);
    do_clear();
    ovl = 1'b0;
    bits(32'b1011011, 7, 1'b0, "t3n");
    check("t3n.total", 32'(match_cnt), 1);
    do_clear();

    // 4: masked middle bit, en=0 gaps with toggling d
    len = 4'd3; pat = 8'b101; care = 8'b101; ovl = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, (k % 3 == 1 && k < 3) ? 1'b0 : 1'b1, 1'b0, "t4");
      tick(1'b0, 1'b0, 1'b0, "t4gap");
      tick(1'b0, 1'b1, 1'b0, "t4gap");
    end
    check("t4.total", 32'(match_cnt), 2);
    care = 8'hFF;
    do_clear();

    // 5: clr on final bit discards it
    pat = 8'b101; ovl = 1'b0;
    tick(1'b1, 1'b1, 1'b0, "t5");
    tick(1'b1, 1'b0, 1'b0, "t5");
    tick(1'b1, 1'b1, 1'b1, "t5clr");
    check("t5.nomatch", 32'(match), 0);
    ovl = 1'b1;
    bits(32'b101, 3, 1'b1, "t5b");
    check("t5b.total", 32'(match_cnt), 1);
    do_clear();

    // 6: counter saturation, then bad length, then async reset
    len = 4'd1; pat = 8'h01; ovl = 1'b1;
    for (int k = 0; k < 20; k++) tick(1'b1, 1'b1, 1'b0, "t6");
    check("t6.cnt", 32'(match_cnt), 15);
    check("t6.sat", 32'(cnt_sat), 1);
    len = 4'd0;
    #1 check("t6.cfg_err", 32'(cfg_err), 1);
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 1'b0, "t6bad");
    len = 4'd9;
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 1'b0, "t6big");
    len = 4'd2;
    mid_reset();
    do_clear();

    // random phase
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 4) == 0) len = 4'($urandom_range(0, 15));
        else len = 4'($urandom_range(1, 4));
        pat  = 8'($urandom);
        care = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
        ovl  = 1'($urandom);
      end
      if ($urandom_range(0, 299) == 0) mid_reset();
      tick(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 59) == 0), "rnd");
    end
    clr = 1'b0;
    en  = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
